cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates the two execution-result sources onto the single common data bus (CDB):
//  RS/ALU results and LSB load/store results.
//  Buffers each source in a small FIFO and grants one result per cycle, round-robin.
//  Drives one registered broadcast that feeds ROB, RS, LSB and the issue stage.
//  A rollback (mispredict) flushes every buffered and in-flight result.
// PARAMETERS
//  DATA_W      32  result width (`DATA_TYPE)
//  ROB_ID_W     4  ROB tag width (`ROB_ID_TYPE)
//  FIFO_DEPTH   2  entries per source FIFO; power of two, >= 2
// PORTS
//  clk             in   1         system clock
//  rst             in   1         asynchronous, active-low reset
//  rdy             in   1         global enable; low = freeze all state
//  rollback        in   1         flush request from ROB
//  rs_valid        in   1         RS result offered
//  rs_rob_id       in   ROB_ID_W  RS result tag
//  rs_result       in   DATA_W    RS result value
//  rs_ready        out  1         RS FIFO can accept
//  ls_valid        in   1         LSB result offered
//  ls_rob_id       in   ROB_ID_W  LSB result tag
//  ls_result       in   DATA_W    LSB result value
//  ls_ready        out  1         LSB FIFO can accept
//  cdb_valid       out  1         broadcast valid this cycle
//  cdb_rob_id      out  ROB_ID_W  broadcast tag
//  cdb_result      out  DATA_W    broadcast value
//  cdb_from_ls     out  1         1 = broadcast came from LSB
// BEHAVIOUR
//  - Reset (rst=0, async): FIFOs empty; cdb_valid/cdb_rob_id/cdb_result/cdb_from_ls = 0;
//    last_grant = LS, so RS wins the first tie.
//  - Ready outputs: x_ready = !full(x), from the registered count only.
//    Full FIFO is not ready even if it is popped the same cycle (no comb. valid->ready path).
//  - Push: on posedge with rdy & !rollback & x_valid & x_ready.
//  - Pop/grant: each rdy cycle, when both FIFOs are non-empty, grant the source != last_grant;
//    otherwise grant the non-empty one.
//    The granted head is popped and registered onto cdb_* (one grant per cycle).
//    last_grant updates only on a grant.
//  - Latency: accepted into an empty FIFO at edge N, broadcast visible after edge N+1.
//    No bypass path.
//  - Idle: no FIFO non-empty -> cdb_valid=0 next cycle; rob_id/result/from_ls hold their values.
//  - Simultaneous push and pop on one FIFO: count unchanged, pointers both advance.
//    Pointers wrap modulo FIFO_DEPTH.
//  - rollback=1 at edge: both FIFOs emptied, cdb_valid=0, pushes that cycle dropped;
//    last_grant kept. rollback overrides rdy.
//  - rdy=0 (and no rollback): no push, no pop, cdb_* and last_grant hold.
//    x_ready still reflects !full.
//  - Arbiter state: last_grant in {GRANT_RS, GRANT_LS}; transitions only on a grant.
// CONFIGURATION
//  CDB_ARB_LS_PRIO_EN defined: fixed priority; LSB wins every tie, last_grant unused.
//  Not defined: round-robin as above.
// STRUCTURE
//  - `constant.v` holds DATA_TYPE, ROB_ID_TYPE, GRANT_RS/GRANT_LS encodings.
//  - Sub-module cdb_fifo (sync FIFO: push/pop/flush/full/empty, head data combinational),
//    instantiated once per source.
//  - Top level holds the grant logic and the output registers.
// TESTING
//  1 Reset: rst=0 mid-run with both FIFOs holding data -> cdb_valid=0 immediately;
//    after release, rs_ready=ls_ready=1.
//  2 Single source: rs push {id=3,0xDEAD} at edge N -> cdb_valid=1, id=3, from_ls=0
//    after N+1 only; idle after.
//  3 Tie: both FIFOs hold 2 entries (RS ids 1,2; LS ids 5,6) -> broadcast order 1,5,2,6.
//    With CDB_ARB_LS_PRIO_EN: 5,6,1,2.
//  4 Full: DEPTH=2, 3 back-to-back ls pushes with no grants -> ls_ready=0 after 2;
//    third held by source, not lost.
//  5 Rollback with 2+2 entries plus cdb_valid=1 -> next cycle cdb_valid=0,
//    both FIFOs empty, same-cycle pushes ignored.
//  6 rdy=0 for 3 cycles with pending entries -> cdb_* frozen, no pops;
//    on rdy=1, order unchanged vs scenario 3.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: default widths and grant encoding.
// Round-robin pick helper used when CDB_ARB_LS_PRIO_EN is not defined.
package cdb_arbiter_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ROB_ID_W_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        GRANT_RS = 1'b0,
        GRANT_LS = 1'b1
    } grant_e;

    function automatic grant_e rr_pick(
        input logic   rs_ne,
        input logic   ls_ne,
        input grant_e last
    );
        if (rs_ne && ls_ne)
            return (last == GRANT_RS) ? GRANT_LS : GRANT_RS;
        return ls_ne ? GRANT_LS : GRANT_RS;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source handshakes and CDB broadcast bundle for cdb_arbiter.
// master = execution units / consumers side, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
);
    logic                rs_valid;
    logic [ROB_ID_W-1:0] rs_rob_id;
    logic [DATA_W-1:0]   rs_result;
    logic                rs_ready;
    logic                ls_valid;
    logic [ROB_ID_W-1:0] ls_rob_id;
    logic [DATA_W-1:0]   ls_result;
    logic                ls_ready;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [DATA_W-1:0]   cdb_result;
    logic                cdb_from_ls;

    modport master (
        output rs_valid, rs_rob_id, rs_result,
        output ls_valid, ls_rob_id, ls_result,
        input  rs_ready, ls_ready,
        input  cdb_valid, cdb_rob_id, cdb_result, cdb_from_ls
    );

    modport slave (
        input  rs_valid, rs_rob_id, rs_result,
        input  ls_valid, ls_rob_id, ls_result,
        output rs_ready, ls_ready,
        output cdb_valid, cdb_rob_id, cdb_result, cdb_from_ls
    );

endinterface

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO with flush; head entry is presented combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers RS and LSB results, grants one per cycle.
// Define CDB_ARB_LS_PRIO_EN for fixed LSB priority instead of round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ROB_ID_W   = ROB_ID_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    cdb_arbiter_if.slave  bus
);

    localparam int EW = ROB_ID_W + DATA_W;

    logic [EW-1:0] rs_head;
    logic [EW-1:0] ls_head;
    logic          rs_full;
    logic          rs_empty;
    logic          ls_full;
    logic          ls_empty;
    logic          live;
    logic          any_ne;
    logic          rs_push;
    logic          ls_push;
    logic          rs_pop;
    logic          ls_pop;
    grant_e        grant;
    grant_e        last_grant;

    logic                valid_q;
    logic [ROB_ID_W-1:0] id_q;
    logic [DATA_W-1:0]   res_q;
    logic                from_ls_q;

    // rollback dominates rdy for every state change
    assign live    = rdy & ~rollback;
    assign any_ne  = ~rs_empty | ~ls_empty;
    assign rs_push = live & bus.rs_valid & ~rs_full;
    assign ls_push = live & bus.ls_valid & ~ls_full;
    assign rs_pop  = live & ~rs_empty & (grant == GRANT_RS);
    assign ls_pop  = live & ~ls_empty & (grant == GRANT_LS);

    assign bus.rs_ready    = ~rs_full;
    assign bus.ls_ready    = ~ls_full;
    assign bus.cdb_valid   = valid_q;
    assign bus.cdb_rob_id  = id_q;
    assign bus.cdb_result  = res_q;
    assign bus.cdb_from_ls = from_ls_q;

    always_comb begin
        grant = GRANT_RS;
`ifdef CDB_ARB_LS_PRIO_EN
        grant = ls_empty ? GRANT_RS : GRANT_LS;
`else
        grant = rr_pick(~rs_empty, ~ls_empty, last_grant);
`endif
    end

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_rs_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rs_push),
        .pop   (rs_pop),
        .flush (rollback),
        .din   ({bus.rs_rob_id, bus.rs_result}),
        .head  (rs_head),
        .full  (rs_full),
        .empty (rs_empty)
    );

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_ls_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ls_push),
        .pop   (ls_pop),
        .flush (rollback),
        .din   ({bus.ls_rob_id, bus.ls_result}),
        .head  (ls_head),
        .full  (ls_full),
        .empty (ls_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            id_q       <= '0;
            res_q      <= '0;
            from_ls_q  <= 1'b0;
            last_grant <= GRANT_LS;
        end else if (rollback) begin
            valid_q <= 1'b0;
        end else if (rdy) begin
            valid_q <= any_ne;
            if (any_ne) begin
                last_grant    <= grant;
                from_ls_q     <= (grant == GRANT_LS);
                {id_q, res_q} <= (grant == GRANT_LS) ? ls_head : rs_head;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, arbitration order,
// back-pressure, rollback flush and rdy freeze.
module tb_cdb_arbiter;

    logic clk;
    logic rst;
    logic rdy;
    logic rollback;
    int   total;
    int   bad;
    int   rs_n;
    int   ls_n;

    cdb_arbiter_if #(.DATA_W(32), .ROB_ID_W(4)) bus ();

    cdb_arbiter #(.DATA_W(32), .ROB_ID_W(4), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rs(input logic v, input int id);
        bus.rs_valid  = v;
        bus.rs_rob_id = 4'(id);
        bus.rs_result = 32'h100 + 32'(id);
    endtask

    task automatic drive_ls(input logic v, input int id);
        bus.ls_valid  = v;
        bus.ls_rob_id = 4'(id);
        bus.ls_result = 32'h200 + 32'(id);
    endtask

    // source holds its offer until it is accepted
    task automatic src_step();
        logic ra;
        logic la;
        ra = bus.rs_ready;
        la = bus.ls_ready;
        tick();
        if (ra) rs_n++;
        if (la) ls_n++;
        drive_rs(1'b1, rs_n);
        drive_ls(1'b1, ls_n);
    endtask

    int exp_id [4];
    int exp_ls [4];
    int s4_id  [7];
    int s4_v   [7];
    int s4_lr  [7];

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        rdy = 1'b1;
        rollback = 1'b0;
        drive_rs(1'b0, 0);
        drive_ls(1'b0, 0);
        tick();
        tick();
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_id", 64'(bus.cdb_rob_id), 64'd0);
        chk("rst_res", 64'(bus.cdb_result), 64'd0);
        chk("rst_from_ls", 64'(bus.cdb_from_ls), 64'd0);
        chk("rst_rs_ready", 64'(bus.rs_ready), 64'd1);
        chk("rst_ls_ready", 64'(bus.ls_ready), 64'd1);
        rst = 1'b1;
        tick();

        // single source latency
        bus.rs_valid  = 1'b1;
        bus.rs_rob_id = 4'd3;
        bus.rs_result = 32'hDEAD;
        tick();
        chk("s2_no_bypass", 64'(bus.cdb_valid), 64'd0);
        drive_rs(1'b0, 0);
        tick();
        chk("s2_valid", 64'(bus.cdb_valid), 64'd1);
        chk("s2_id", 64'(bus.cdb_rob_id), 64'd3);
        chk("s2_res", 64'(bus.cdb_result), 64'h0000_DEAD);
        chk("s2_from_ls", 64'(bus.cdb_from_ls), 64'd0);
        tick();
        chk("s2_idle", 64'(bus.cdb_valid), 64'd0);
        chk("s2_hold_id", 64'(bus.cdb_rob_id), 64'd3);

        // async reset with data buffered and a live broadcast
        drive_rs(1'b1, 7);
        drive_ls(1'b1, 8);
        tick();
        drive_rs(1'b1, 9);
        drive_ls(1'b1, 10);
        tick();
`ifndef CDB_ARB_LS_PRIO_EN
        chk("r_pre_id", 64'(bus.cdb_rob_id), 64'd8);
        chk("r_pre_rs_ready", 64'(bus.rs_ready), 64'd0);
`endif
        chk("r_pre_valid", 64'(bus.cdb_valid), 64'd1);
        drive_rs(1'b0, 0);
        drive_ls(1'b0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("r_async_valid", 64'(bus.cdb_valid), 64'd0);
        chk("r_async_id", 64'(bus.cdb_rob_id), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("r_rs_ready", 64'(bus.rs_ready), 64'd1);
        chk("r_ls_ready", 64'(bus.ls_ready), 64'd1);
        chk("r_empty", 64'(bus.cdb_valid), 64'd0);

        // tie order
`ifdef CDB_ARB_LS_PRIO_EN
        exp_id = '{5, 6, 1, 2};
        exp_ls = '{1, 1, 0, 0};
`else
        exp_id = '{1, 5, 2, 6};
        exp_ls = '{0, 1, 0, 1};
`endif
        drive_rs(1'b1, 1);
        drive_ls(1'b1, 5);
        tick();
        chk("s3_first", 64'(bus.cdb_valid), 64'd0);
        drive_rs(1'b1, 2);
        drive_ls(1'b1, 6);
        tick();
        drive_rs(1'b0, 0);
        drive_ls(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s3_v%0d", i), 64'(bus.cdb_valid), 64'd1);
            chk($sformatf("s3_id%0d", i), 64'(bus.cdb_rob_id), 64'(exp_id[i]));
            chk($sformatf("s3_ls%0d", i), 64'(bus.cdb_from_ls), 64'(exp_ls[i]));
            chk($sformatf("s3_res%0d", i), 64'(bus.cdb_result),
                64'(32'h100 + 32'h100 * 32'(exp_ls[i]) + 32'(exp_id[i])));
            if (i < 3) tick();
        end
        tick();
        chk("s3_idle", 64'(bus.cdb_valid), 64'd0);

`ifndef CDB_ARB_LS_PRIO_EN
        // back-pressure: both sources stream, LS fills first
        s4_v  = '{0, 1, 1, 1, 1, 1, 1};
        s4_id = '{0, 1, 9, 2, 10, 3, 11};
        s4_lr = '{1, 0, 1, 0, 1, 0, 1};
        rs_n = 1;
        ls_n = 9;
        drive_rs(1'b1, rs_n);
        drive_ls(1'b1, ls_n);
        for (int i = 0; i < 7; i++) begin
            src_step();
            chk($sformatf("s4_v%0d", i), 64'(bus.cdb_valid), 64'(s4_v[i]));
            if (s4_v[i] != 0)
                chk($sformatf("s4_id%0d", i), 64'(bus.cdb_rob_id),
                    64'(s4_id[i]));
            chk($sformatf("s4_lr%0d", i), 64'(bus.ls_ready), 64'(s4_lr[i]));
        end
        chk("s4_rs_full", 64'(bus.rs_ready), 64'd0);

        // rollback with buffered entries and same-cycle pushes
        rollback = 1'b1;
        tick();
        chk("s5_valid", 64'(bus.cdb_valid), 64'd0);
        chk("s5_rs_ready", 64'(bus.rs_ready), 64'd1);
        chk("s5_ls_ready", 64'(bus.ls_ready), 64'd1);
        rollback = 1'b0;
        drive_rs(1'b0, 0);
        drive_ls(1'b0, 0);
        tick();
        chk("s5_dropped", 64'(bus.cdb_valid), 64'd0);
        chk("s5_hold_id", 64'(bus.cdb_rob_id), 64'd11);
        tick();
        chk("s5_still_idle", 64'(bus.cdb_valid), 64'd0);

        // rdy freeze in the middle of the tie sequence
        drive_rs(1'b1, 1);
        drive_ls(1'b1, 5);
        tick();
        drive_rs(1'b1, 2);
        drive_ls(1'b1, 6);
        tick();
        drive_rs(1'b1, 14);
        drive_ls(1'b0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s6_fv%0d", i), 64'(bus.cdb_valid), 64'd1);
            chk($sformatf("s6_fid%0d", i), 64'(bus.cdb_rob_id), 64'd1);
            chk($sformatf("s6_flr%0d", i), 64'(bus.ls_ready), 64'd0);
            tick();
        end
        rdy = 1'b1;
        drive_rs(1'b0, 0);
        tick();
        chk("s6_id1", 64'(bus.cdb_rob_id), 64'd5);
        chk("s6_ls1", 64'(bus.cdb_from_ls), 64'd1);
        tick();
        chk("s6_id2", 64'(bus.cdb_rob_id), 64'd2);
        tick();
        chk("s6_id3", 64'(bus.cdb_rob_id), 64'd6);
        tick();
        chk("s6_idle", 64'(bus.cdb_valid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
